// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports, the RAM port and debug taps for mem_port_arbiter.
// req/gnt: a requester holds req/addr/wdata until it sees gnt. A gnt marks the cycle the
// access is issued. Read data comes back one cycle after its gnt with rvalid, and there is no backpressure.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          working;

  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;

  logic          dat_req;
  logic          dat_we;
  logic [AW-1:0] dat_addr;
  logic [DW-1:0] dat_wdata;
  logic          dat_gnt;
  logic          dat_rvalid;
  logic [DW-1:0] dat_rdata;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_starved;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Debug taps. Read owner encoding: 0 = none, 1 = data, 2 = fetch.
  logic [1:0]    dbg_rd_owner;
  logic [3:0]    dbg_wait_cnt;

  modport slave (
    input  working,
    input  host_req, host_addr, host_wdata,
    output host_gnt,
    input  dat_req, dat_we, dat_addr, dat_wdata,
    output dat_gnt, dat_rvalid, dat_rdata,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_starved,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output dbg_rd_owner, dbg_wait_cnt
  );

  modport master (
    output working,
    output host_req, host_addr, host_wdata,
    input  host_gnt,
    output dat_req, dat_we, dat_addr, dat_wdata,
    input  dat_gnt, dat_rvalid, dat_rdata,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_starved,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  dbg_rd_owner, dbg_wait_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: host > data > fetch with same-cycle grants, plus an aging
// counter that promotes a starved fetch over data. Read data is tagged back one cycle later.
module mem_port_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DAT  = 2'd1,
    OWN_IF   = 2'd2
  } owner_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_e     rd_owner, rd_owner_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       if_elig;
  logic       starved;
  logic       gnt_host, gnt_dat, gnt_if;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
      wait_cnt <= 4'd0;
    end else begin
      rd_owner <= rd_owner_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Grant selection. A starved fetch jumps ahead of data but never ahead of the host.
  always_comb begin
    if_elig  = bus.if_req && bus.working;
    starved  = (wait_cnt == WAIT_MAX);
    gnt_host = 1'b0;
    gnt_dat  = 1'b0;
    gnt_if   = 1'b0;
    if (!reset) begin
      if (bus.host_req)           gnt_host = 1'b1;
      else if (if_elig && starved) gnt_if  = 1'b1;
      else if (bus.dat_req)       gnt_dat  = 1'b1;
      else if (if_elig)           gnt_if   = 1'b1;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_host) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else if (gnt_dat) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dat_we;
      bus.mem_addr  = bus.dat_addr;
      bus.mem_wdata = bus.dat_wdata;
    end else if (gnt_if) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr;
    end
  end

  // Next owner of the RAM read return and the fetch aging count.
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    wait_cnt_nxt = 4'd0;
    if (gnt_dat && !bus.dat_we) rd_owner_nxt = OWN_DAT;
    else if (gnt_if)            rd_owner_nxt = OWN_IF;
    if (if_elig && !gnt_if)
      wait_cnt_nxt = starved ? wait_cnt : wait_cnt + 4'd1;
  end

  assign bus.host_gnt   = gnt_host;
  assign bus.dat_gnt    = gnt_dat;
  assign bus.if_gnt     = gnt_if;
  assign bus.if_starved = starved;

  // A read issued just before reset is dropped, so its return is masked while reset is high.
  assign bus.dat_rvalid = (rd_owner == OWN_DAT) && !reset;
  assign bus.if_rvalid  = (rd_owner == OWN_IF)  && !reset;
  assign bus.dat_rdata  = bus.dat_rvalid ? bus.mem_rdata : '0;
  assign bus.if_rdata   = bus.if_rvalid  ? bus.mem_rdata : '0;

  assign bus.dbg_rd_owner = rd_owner;
  assign bus.dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, per-cycle reference model with a return queue,
// directed scenarios with literal expectations, then a randomised soak.
module tb_mem_port_arbiter;
  localparam int AW       = 9;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM with registered read, driven only by the DUT's memory port
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // scoreboard state
  int               n_checks = 0;
  int               n_fail   = 0;
  logic             chk_en   = 1'b0;
  logic [DW-1:0]    shadow [DEPTH];
  logic [DW+1:0]    exp_q[$];
  int               m_wait   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: winner: 0 idle, 1 host, 2 data, 3 fetch; return tag: 0 none, 1 data, 2 fetch.
  task automatic model_cycle();
    logic [DW+1:0] ret;
    logic [1:0]    tag;
    logic [DW-1:0] rdat;
    logic          elig;
    int            win;
    ret = '0;
    if (exp_q.size() != 0) ret = exp_q.pop_front();
    tag  = ret[DW+1:DW];
    rdat = ret[DW-1:0];

    check("dbg_rd_owner", 64'(bus.dbg_rd_owner), 64'(tag));
    check("dat_rvalid", 64'(bus.dat_rvalid), 64'(!reset && tag == 2'd1));
    check("dat_rdata",  64'(bus.dat_rdata),  (!reset && tag == 2'd1) ? 64'(rdat) : 64'd0);
    check("if_rvalid",  64'(bus.if_rvalid),  64'(!reset && tag == 2'd2));
    check("if_rdata",   64'(bus.if_rdata),   (!reset && tag == 2'd2) ? 64'(rdat) : 64'd0);
    check("if_starved", 64'(bus.if_starved), 64'(m_wait == MAX_WAIT));
    check("dbg_wait_cnt", 64'(bus.dbg_wait_cnt), 64'(m_wait));

    elig = bus.if_req && bus.working;
    if (reset)                            win = 0;
    else if (bus.host_req)                win = 1;
    else if (elig && m_wait == MAX_WAIT)  win = 3;
    else if (bus.dat_req)                 win = 2;
    else if (elig)                        win = 3;
    else                                  win = 0;

    check("host_gnt", 64'(bus.host_gnt), 64'(win == 1));
    check("dat_gnt",  64'(bus.dat_gnt),  64'(win == 2));
    check("if_gnt",   64'(bus.if_gnt),   64'(win == 3));
    check("mem_en",   64'(bus.mem_en),   64'(win != 0));
    case (win)
      1: begin
        check("mem_we", 64'(bus.mem_we), 64'd1);
        check("mem_addr", 64'(bus.mem_addr), 64'(bus.host_addr));
        check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.host_wdata));
        shadow[bus.host_addr] = bus.host_wdata;
        exp_q.push_back('0);
      end
      2: begin
        check("mem_we", 64'(bus.mem_we), 64'(bus.dat_we));
        check("mem_addr", 64'(bus.mem_addr), 64'(bus.dat_addr));
        check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.dat_wdata));
        if (bus.dat_we) begin
          shadow[bus.dat_addr] = bus.dat_wdata;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back({2'd1, shadow[bus.dat_addr]});
        end
      end
      3: begin
        check("mem_we", 64'(bus.mem_we), 64'd0);
        check("mem_addr", 64'(bus.mem_addr), 64'(bus.if_addr));
        check("mem_wdata", 64'(bus.mem_wdata), 64'd0);
        exp_q.push_back({2'd2, shadow[bus.if_addr]});
      end
      default: begin
        check("mem_we", 64'(bus.mem_we), 64'd0);
        check("mem_addr", 64'(bus.mem_addr), 64'd0);
        check("mem_wdata", 64'(bus.mem_wdata), 64'd0);
        exp_q.push_back('0);
      end
    endcase

    if (reset)                 m_wait = 0;
    else if (elig && win != 3) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else                       m_wait = 0;
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) model_cycle();
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic drop_all();
    bus.host_req = 1'b0;
    bus.dat_req  = 1'b0;
    bus.if_req   = 1'b0;
  endtask

  initial begin
    logic [5:0] seq_dat;
    logic [5:0] seq_if;
    seq_dat = 6'b101111;
    seq_if  = 6'b010000;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'hA5A5_0000 | 32'(i);
      shadow[i] = 32'hA5A5_0000 | 32'(i);
    end
    ram[5]    = 32'hDEAD_BEEF;
    shadow[5] = 32'hDEAD_BEEF;
    bus.mem_rdata = '0;

    // reset held with every requester active
    reset          = 1'b1;
    bus.working    = 1'b1;
    bus.host_req   = 1'b1;
    bus.host_addr  = 9'h010;
    bus.host_wdata = 32'h1234_5678;
    bus.dat_req    = 1'b1;
    bus.dat_we     = 1'b0;
    bus.dat_addr   = 9'h030;
    bus.dat_wdata  = '0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 9'h005;
    step();
    chk_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_host_gnt", 64'(bus.host_gnt), 64'd0);
      check("rst_dat_gnt", 64'(bus.dat_gnt), 64'd0);
      check("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      step();
    end

    // first cycle out of reset: host wins
    reset = 1'b0;
    settle();
    check("lit_host_gnt", 64'(bus.host_gnt), 64'd1);
    check("lit_host_we", 64'(bus.mem_we), 64'd1);
    check("lit_host_addr", 64'(bus.mem_addr), 64'h010);
    check("lit_post_rst_dat_rvalid", 64'(bus.dat_rvalid), 64'd0);
    check("lit_post_rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    step();
    bus.host_req = 1'b0;
    settle();
    check("lit_dat_after_host", 64'(bus.dat_gnt), 64'd1);
    step();
    bus.dat_req = 1'b0;
    settle();
    check("lit_fetch_gnt", 64'(bus.if_gnt), 64'd1);
    check("lit_fetch_addr", 64'(bus.mem_addr), 64'h005);
    check("lit_dat_rdata", 64'(bus.dat_rdata), 64'hA5A5_0030);
    step();
    bus.if_req = 1'b0;
    settle();
    check("lit_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("lit_if_rdata", 64'(bus.if_rdata), 64'hDEAD_BEEF);
    check("lit_if_ret_dat_rvalid", 64'(bus.dat_rvalid), 64'd0);

    // data and fetch held: fetch promoted on the 5th cycle
    step();
    bus.dat_req  = 1'b1;
    bus.dat_we   = 1'b0;
    bus.dat_addr = 9'h031;
    bus.if_req   = 1'b1;
    bus.if_addr  = 9'h006;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("lit_age_dat_gnt", 64'(bus.dat_gnt), 64'(seq_dat[c]));
      check("lit_age_if_gnt", 64'(bus.if_gnt), 64'(seq_if[c]));
      check("lit_age_starved", 64'(bus.if_starved), 64'(seq_if[c]));
      if (c > 0) begin
        check("lit_age_dat_tag", 64'(bus.dat_rvalid), 64'(seq_dat[c-1]));
        check("lit_age_if_tag", 64'(bus.if_rvalid), 64'(seq_if[c-1]));
      end
      if (c == 5) begin
        check("lit_age_wait_clear", 64'(bus.dbg_wait_cnt), 64'd0);
        check("lit_age_if_rdata", 64'(bus.if_rdata), 64'hA5A5_0006);
      end
      step();
    end
    drop_all();
    settle();
    check("lit_age_last_dat_tag", 64'(bus.dat_rvalid), 64'd1);

    // host preempts a promoted fetch; the count stays saturated
    step();
    bus.dat_req  = 1'b1;
    bus.dat_addr = 9'h032;
    bus.if_req   = 1'b1;
    repeat (4) step();
    bus.host_req   = 1'b1;
    bus.host_addr  = 9'h040;
    bus.host_wdata = 32'h0BAD_F00D;
    settle();
    check("lit_pre_host_gnt", 64'(bus.host_gnt), 64'd1);
    check("lit_pre_if_gnt", 64'(bus.if_gnt), 64'd0);
    check("lit_pre_starved", 64'(bus.if_starved), 64'd1);
    step();
    bus.host_req = 1'b0;
    settle();
    check("lit_pre_still_starved", 64'(bus.if_starved), 64'd1);
    check("lit_pre_if_after_host", 64'(bus.if_gnt), 64'd1);
    step();
    drop_all();

    // working low: fetch ineligible, data write proceeds
    step();
    bus.working   = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 9'h007;
    bus.dat_req   = 1'b1;
    bus.dat_we    = 1'b1;
    bus.dat_addr  = 9'h020;
    bus.dat_wdata = 32'hCAFE_F00D;
    settle();
    check("lit_wr_dat_gnt", 64'(bus.dat_gnt), 64'd1);
    check("lit_wr_we", 64'(bus.mem_we), 64'd1);
    check("lit_wr_addr", 64'(bus.mem_addr), 64'h020);
    check("lit_wr_if_gnt", 64'(bus.if_gnt), 64'd0);
    check("lit_wr_wait", 64'(bus.dbg_wait_cnt), 64'd0);
    step();
    bus.dat_req = 1'b0;
    settle();
    check("lit_idle_if_gnt", 64'(bus.if_gnt), 64'd0);
    check("lit_wr_no_rvalid", 64'(bus.dat_rvalid | bus.if_rvalid), 64'd0);
    check("lit_idle_wait", 64'(bus.dbg_wait_cnt), 64'd0);
    step();
    bus.dat_req = 1'b1;
    bus.dat_we  = 1'b0;
    step();
    bus.dat_req = 1'b0;
    settle();
    check("lit_readback", 64'(bus.dat_rdata), 64'hCAFE_F00D);

    // working falls while a fetch read is in flight
    step();
    bus.working = 1'b1;
    bus.if_addr = 9'h008;
    settle();
    check("lit_wfall_gnt", 64'(bus.if_gnt), 64'd1);
    step();
    bus.working = 1'b0;
    settle();
    check("lit_wfall_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("lit_wfall_rdata", 64'(bus.if_rdata), 64'hA5A5_0008);
    step();
    bus.if_req = 1'b0;

    // read granted, then reset the next cycle
    bus.dat_req  = 1'b1;
    bus.dat_addr = 9'h033;
    settle();
    check("lit_rr_dat_gnt", 64'(bus.dat_gnt), 64'd1);
    step();
    reset       = 1'b1;
    bus.dat_req = 1'b0;
    settle();
    check("lit_rr_rvalid", 64'(bus.dat_rvalid), 64'd0);
    check("lit_rr_rdata", 64'(bus.dat_rdata), 64'd0);
    step();
    reset = 1'b0;
    settle();
    check("lit_rr_owner", 64'(bus.dbg_rd_owner), 64'd0);
    check("lit_rr_after", 64'(bus.dat_rvalid), 64'd0);

    // randomised soak against the model
    for (int c = 0; c < 300; c++) begin
      step();
      reset          = ($urandom_range(0, 49) == 0);
      bus.working    = ($urandom_range(0, 7) != 0);
      bus.host_req   = ($urandom_range(0, 4) == 0);
      bus.host_addr  = 9'($urandom_range(0, 63));
      bus.host_wdata = $urandom();
      bus.dat_req    = ($urandom_range(0, 2) != 0);
      bus.dat_we     = ($urandom_range(0, 2) == 0);
      bus.dat_addr   = 9'($urandom_range(0, 63));
      bus.dat_wdata  = $urandom();
      bus.if_req     = ($urandom_range(0, 3) != 0);
      bus.if_addr    = 9'($urandom_range(0, 63));
    end
    step();
    reset = 1'b0;
    drop_all();
    repeat (3) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
